// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage feeding the control unit. Holds the PC, requests one
//   instruction word at a time over a req/ack handshake, latches it into
//   the instruction register (IR) and presents the decoded fields.
//   While no live instruction is held, opcode reads 4'b1111 (control-unit
//   no-op) and rd/rs/imm read 0.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request, held until acked
//   imem_addr    out  fetch address (= PC)
//   imem_ack     in   imem_rdata valid this cycle
//   imem_rdata   in   instruction word {opcode, rd, rs, imm}
//   stall        in   downstream cannot take a new instruction
//   redirect     in   branch/jump taken, reload PC from redirect_pc
//   redirect_pc  in   new PC
//   opcode       out  IR[15:12] or 4'b1111 when not valid
//   rd, rs, imm  out  IR fields or 0 when not valid
//   instr_valid  out  IR holds a live instruction
//   pc_out       out  address of the instruction in IR
//   fetch_error  out  sticky fetch timeout flag
//
// Build option
//   FETCH_TIMEOUT_EN : when defined, a fetch that waits TIMEOUT_CYCLES
//   without an ack sets fetch_error and restarts the request. When not
//   defined, FETCH waits forever and fetch_error is constant 0.

module instr_fetch_unit #(
  parameter int                ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        imm,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_error
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pc_out_reg, pc_out_next;
  logic [15:0]       ir_reg, ir_next;
  logic              req_reg, req_next;
  logic              accept;

  // An ack only counts while a request is actually on the bus; this keeps
  // the reset-release cycle (request still low) from latching stray data.
  assign accept = (state_reg == FETCH) && req_reg && imem_ack;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    pc_out_next = pc_out_reg;
    ir_next     = ir_reg;
    if (redirect) begin
      // Redirect beats everything, including an ack or stall this cycle.
      pc_next    = redirect_pc;
      state_next = FETCH;
    end else begin
      case (state_reg)
        FETCH: begin
          if (accept) begin
            ir_next     = imem_rdata;
            pc_out_next = pc_reg;
            pc_next     = pc_reg + 1'b1;  // wraps modulo 2^ADDR_W
            state_next  = ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
    // Request is a registered copy of "next state is FETCH", so it depends
    // on state only and reads 0 straight out of reset.
    req_next = (state_next == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_PC;
      pc_out_reg <= RESET_PC;
      ir_reg     <= 16'hF000;
      req_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      pc_out_reg <= pc_out_next;
      ir_reg     <= ir_next;
      req_reg    <= req_next;
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign instr_valid = (state_reg == ISSUE);
  assign pc_out      = pc_out_reg;
  assign opcode      = instr_valid ? ir_reg[15:12] : 4'b1111;
  assign rd          = instr_valid ? ir_reg[11:8]  : 4'd0;
  assign rs          = instr_valid ? ir_reg[7:4]   : 4'd0;
  assign imm         = instr_valid ? ir_reg[3:0]   : 4'd0;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             fetch_error_reg;

  // Counts request cycles without an ack. Hitting the limit abandons the
  // request: PC and state are left alone so the same address is simply
  // re-requested, and the counter starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg    <= '0;
      fetch_error_reg <= 1'b0;
    end else if (redirect || accept || (state_reg != FETCH) || !req_reg) begin
      wait_cnt_reg <= '0;
    end else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      wait_cnt_reg    <= '0;
      fetch_error_reg <= 1'b1;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign fetch_error = fetch_error_reg;
`else
  // No timeout hardware; the expression is constant 0 for any legal
  // (non-negative) TIMEOUT_CYCLES.
  assign fetch_error = (TIMEOUT_CYCLES < 0);
`endif

endmodule
